// File: rtl/hazard_interlock_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_interlock_unit_if
// Brief    : Pipeline-side bundle between the OF/EX stages and the interlock unit
// Revision : 1.0
// ============================================================================
interface hazard_interlock_unit_if #(
    parameter int CNT_W = 16
) ();
    logic [31:0]      of_ir;
    logic [31:0]      ex_ir;
    logic             branch_taken;
    logic             pc_hold;
    logic             if_of_hold;
    logic             if_of_flush;
    logic             of_ex_hold;
    logic             of_ex_bubble;
    logic             ex_ma_bubble;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [1:0]       state;

    modport master (
        output of_ir, ex_ir, branch_taken,
        input  pc_hold, if_of_hold, if_of_flush, of_ex_hold, of_ex_bubble,
        input  ex_ma_bubble, stall_cnt, flush_cnt, state
    );

    modport slave (
        input  of_ir, ex_ir, branch_taken,
        output pc_hold, if_of_hold, if_of_flush, of_ex_hold, of_ex_bubble,
        output ex_ma_bubble, stall_cnt, flush_cnt, state
    );
endinterface
`default_nettype wire

// File: rtl/hazard_interlock_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_interlock_unit
// Brief    : Stall/flush controller for the 5-stage SimpleRISC pipeline
// Revision : 1.0
// ============================================================================
module hazard_interlock_unit #(
    parameter int DIV_LATENCY = 4,
    parameter int CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    hazard_interlock_unit_if.slave  bus
);
    localparam logic [4:0] c_OP_DIV  = 5'b00011;
    localparam logic [4:0] c_OP_MOD  = 5'b00100;
    localparam logic [4:0] c_OP_NOT  = 5'b01000;
    localparam logic [4:0] c_OP_MOV  = 5'b01001;
    localparam logic [4:0] c_OP_ALU_MAX = 5'b01100;
    localparam logic [4:0] c_OP_NOP  = 5'b01101;
    localparam logic [4:0] c_OP_LD   = 5'b01110;
    localparam logic [4:0] c_OP_ST   = 5'b01111;
    localparam logic [4:0] c_OP_BEQ  = 5'b10000;
    localparam logic [4:0] c_OP_BGT  = 5'b10001;
    localparam logic [4:0] c_OP_B    = 5'b10010;
    localparam logic [4:0] c_OP_CALL = 5'b10011;
    localparam logic [4:0] c_OP_RET  = 5'b10100;
    localparam logic [3:0] c_REG_RA  = 4'd15;

    localparam bit c_DIV_STALLS = (DIV_LATENCY >= 2);
    localparam int c_CW         = (DIV_LATENCY > 2) ? $clog2(DIV_LATENCY) : 1;
    localparam logic [c_CW-1:0] c_DIV_LOAD = c_CW'((DIV_LATENCY >= 2) ? (DIV_LATENCY - 2) : 0);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_BUSY = 2'd1
    } state_t;

    state_t           r_state;
    logic [c_CW-1:0]  r_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    wire [4:0] w_of_op  = bus.of_ir[31:27];
    wire       w_of_imm = bus.of_ir[26];
    wire [3:0] w_of_rd  = bus.of_ir[25:22];
    wire [3:0] w_of_rs1 = bus.of_ir[21:18];
    wire [3:0] w_of_rs2 = bus.of_ir[17:14];
    wire [4:0] w_ex_op  = bus.ex_ir[31:27];
    wire [3:0] w_ex_rd  = bus.ex_ir[25:22];
    wire       w_unused = ^{bus.of_ir[13:0], bus.ex_ir[26], bus.ex_ir[21:0]};

    logic       w_reads_rs1;
    logic       w_reads_rs2;
    logic       w_reads_rd;
    logic [3:0] w_src1;
    logic       w_load_use;
    logic       w_div;

    always_comb begin
        w_reads_rs1 = !(w_of_op inside {c_OP_NOP, c_OP_B, c_OP_BEQ, c_OP_BGT,
                                        c_OP_CALL, c_OP_NOT, c_OP_MOV});
        // ret reads the return address register regardless of the rs1 field
        w_src1      = (w_of_op == c_OP_RET) ? c_REG_RA : w_of_rs1;
        w_reads_rs2 = !w_of_imm && (w_of_op <= c_OP_ALU_MAX);
        w_reads_rd  = (w_of_op == c_OP_ST);
        w_load_use  = (w_ex_op == c_OP_LD) &&
                      ((w_reads_rs1 && (w_src1   == w_ex_rd)) ||
                       (w_reads_rs2 && (w_of_rs2 == w_ex_rd)) ||
                       (w_reads_rd  && (w_of_rd  == w_ex_rd)));
        w_div       = (w_ex_op == c_OP_DIV) || (w_ex_op == c_OP_MOD);
    end

    logic w_pc_hold;
    logic w_if_of_hold;
    logic w_if_of_flush;
    logic w_of_ex_hold;
    logic w_of_ex_bubble;
    logic w_ex_ma_bubble;
    logic w_div_hold;

    always_comb begin
        w_pc_hold      = 1'b0;
        w_if_of_hold   = 1'b0;
        w_if_of_flush  = 1'b0;
        w_of_ex_hold   = 1'b0;
        w_of_ex_bubble = 1'b0;
        w_ex_ma_bubble = 1'b0;
        w_div_hold     = 1'b0;
        if (rst_n) begin
            if (bus.branch_taken) begin
                w_if_of_flush  = 1'b1;
                w_of_ex_bubble = 1'b1;
            end else if (r_state == DIV_BUSY) begin
                w_div_hold = (r_cnt != '0);
            end else if (w_div && c_DIV_STALLS) begin
                w_div_hold = 1'b1;
            end else if (w_load_use) begin
                w_pc_hold      = 1'b1;
                w_if_of_hold   = 1'b1;
                w_of_ex_bubble = 1'b1;
            end
            if (w_div_hold) begin
                w_pc_hold      = 1'b1;
                w_if_of_hold   = 1'b1;
                w_of_ex_hold   = 1'b1;
                w_ex_ma_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            // a flush aborts any divide sequence so the FSM never outlives its div
            if (bus.branch_taken) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_div && c_DIV_STALLS) begin
                            r_state <= DIV_BUSY;
                            r_cnt   <= c_DIV_LOAD;
                        end
                    end
                    DIV_BUSY: begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - c_CW'(1);
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
            if (w_pc_hold && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (bus.branch_taken && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.pc_hold      = w_pc_hold;
    assign bus.if_of_hold   = w_if_of_hold;
    assign bus.if_of_flush  = w_if_of_flush;
    assign bus.of_ex_hold   = w_of_ex_hold;
    assign bus.of_ex_bubble = w_of_ex_bubble;
    assign bus.ex_ma_bubble = w_ex_ma_bubble;
    assign bus.stall_cnt    = r_stall_cnt;
    assign bus.flush_cnt    = r_flush_cnt;
    assign bus.state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_hazard_interlock_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_interlock_unit
// Brief    : Directed scoreboard bench for the stall/flush controller
// Revision : 1.0
// ============================================================================
module tb_hazard_interlock_unit;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_interlock_unit_if #(.CNT_W(16)) hif ();
    hazard_interlock_unit_if #(.CNT_W(2))  sif ();

    hazard_interlock_unit #(.DIV_LATENCY(4), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (hif)
    );

    // small counters and single-cycle divide for saturation / no-stall checks
    hazard_interlock_unit #(.DIV_LATENCY(1), .CNT_W(2)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif)
    );

    localparam logic [31:0] NOP     = 32'h6800_0000;
    localparam logic [31:0] LD3     = 32'h74C4_0004;
    localparam logic [31:0] ADD_R3  = 32'h010C_8000;
    localparam logic [31:0] ADD_NO  = 32'h0108_8000;
    localparam logic [31:0] ST_R3   = 32'h7CD4_0000;
    localparam logic [31:0] ADD_RS2 = 32'h0108_C000;
    localparam logic [31:0] ADDI    = 32'h0508_C000;
    localparam logic [31:0] LD15    = 32'h77C4_0004;
    localparam logic [31:0] RET     = 32'hA000_0000;
    localparam logic [31:0] B_R15   = 32'h903C_0000;
    localparam logic [31:0] DIV     = 32'h1959_C000;

    // {pc_hold, if_of_hold, if_of_flush, of_ex_hold, of_ex_bubble, ex_ma_bubble}
    localparam logic [5:0] NO = 6'b000000;
    localparam logic [5:0] LU = 6'b110010;
    localparam logic [5:0] DV = 6'b110101;
    localparam logic [5:0] BR = 6'b001010;

    typedef struct {
        string      nm;
        logic [5:0] ctl;
        logic [1:0] st;
        int         stall;
        int         flush;
        logic [5:0] sctl;
        int         sstall;
        int         sflush;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic cmp(string nm, string fld, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s %s: got %0h want %0h", nm, fld, got, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            cmp(e.nm, "ctl", int'({hif.pc_hold, hif.if_of_hold, hif.if_of_flush,
                                   hif.of_ex_hold, hif.of_ex_bubble, hif.ex_ma_bubble}), int'(e.ctl));
            cmp(e.nm, "state", int'(hif.state), int'(e.st));
            cmp(e.nm, "stall_cnt", int'(hif.stall_cnt), e.stall);
            cmp(e.nm, "flush_cnt", int'(hif.flush_cnt), e.flush);
            cmp(e.nm, "sat_ctl", int'({sif.pc_hold, sif.if_of_hold, sif.if_of_flush,
                                       sif.of_ex_hold, sif.of_ex_bubble, sif.ex_ma_bubble}), int'(e.sctl));
            cmp(e.nm, "sat_stall", int'(sif.stall_cnt), e.sstall);
            cmp(e.nm, "sat_flush", int'(sif.flush_cnt), e.sflush);
        end
    end

    task automatic drv(logic [31:0] of, logic [31:0] ex, logic br);
        hif.of_ir = of; hif.ex_ir = ex; hif.branch_taken = br;
    endtask

    task automatic sdrv(logic [31:0] of, logic [31:0] ex, logic br);
        sif.of_ir = of; sif.ex_ir = ex; sif.branch_taken = br;
    endtask

    task automatic push(string nm, logic [5:0] ctl, logic [1:0] st, int s, int f,
                        logic [5:0] sctl, int ss, int sf);
        exp_t e;
        e.nm = nm; e.ctl = ctl; e.st = st; e.stall = s; e.flush = f;
        e.sctl = sctl; e.sstall = ss; e.sflush = sf;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // main-unit check with the small unit idle at zero counts
    task automatic chk(string nm, logic [5:0] ctl, logic [1:0] st, int s, int f);
        push(nm, ctl, st, s, f, NO, 0, 0);
    endtask

    // small-unit check with the main unit parked after the reset sequence
    task automatic schk(string nm, logic [5:0] sctl, int ss, int sf);
        push(nm, NO, 2'd0, 3, 0, sctl, ss, sf);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drv(NOP, NOP, 1'b0);
        sdrv(NOP, NOP, 1'b0);
        @(posedge clk);
        #1;
        chk("reset", NO, 0, 0, 0);
        drv(ADD_R3, LD3, 1'b0);
        chk("rst_gate", NO, 0, 0, 0);
        rst_n = 1'b1;
        drv(NOP, NOP, 1'b0);      chk("release", NO, 0, 0, 0);

        drv(ADD_R3, LD3, 1'b0);   chk("lu_rs1", LU, 0, 0, 0);
        drv(ADD_R3, NOP, 1'b0);   chk("lu_after", NO, 0, 1, 0);
        drv(ADD_NO, LD3, 1'b0);   chk("no_hazard", NO, 0, 1, 0);
        drv(ST_R3, LD3, 1'b0);    chk("lu_store", LU, 0, 1, 0);
        drv(ADD_RS2, LD3, 1'b0);  chk("lu_rs2", LU, 0, 2, 0);
        drv(ADDI, LD3, 1'b0);     chk("imm_no_rs2", NO, 0, 3, 0);
        drv(RET, LD15, 1'b0);     chk("lu_ret_ra", LU, 0, 3, 0);
        drv(B_R15, LD15, 1'b0);   chk("branch_no_rs1", NO, 0, 4, 0);

        drv(NOP, DIV, 1'b0);
        chk("div_det", DV, 0, 4, 0);
        chk("div_b1", DV, 1, 5, 0);
        chk("div_b2", DV, 1, 6, 0);
        chk("div_rel", NO, 1, 7, 0);
        chk("div2_det", DV, 0, 7, 0);
        chk("div2_b1", DV, 1, 8, 0);
        chk("div2_b2", DV, 1, 9, 0);
        chk("div2_rel", NO, 1, 10, 0);
        drv(NOP, NOP, 1'b0);      chk("div_idle", NO, 0, 10, 0);

        drv(NOP, NOP, 1'b1);      chk("br", BR, 0, 10, 0);
        drv(NOP, NOP, 1'b0);      chk("br_after", NO, 0, 10, 1);
        drv(ADD_R3, LD3, 1'b1);   chk("br_over_lu", BR, 0, 10, 1);
        drv(NOP, NOP, 1'b0);      chk("br_lu_after", NO, 0, 10, 2);
        drv(NOP, DIV, 1'b0);      chk("bd_det", DV, 0, 10, 2);
        drv(NOP, DIV, 1'b1);      chk("bd_flush", BR, 1, 11, 2);
        drv(NOP, NOP, 1'b0);      chk("bd_abort", NO, 0, 11, 3);

        drv(NOP, DIV, 1'b0);
        chk("rd_det", DV, 0, 11, 3);
        chk("rd_b1", DV, 1, 12, 3);
        rst_n = 1'b0;
        chk("rd_reset", NO, 0, 0, 0);
        rst_n = 1'b1;
        chk("rd_det2", DV, 0, 0, 0);
        chk("rd_b1_2", DV, 1, 1, 0);
        chk("rd_b2_2", DV, 1, 2, 0);
        chk("rd_rel", NO, 1, 3, 0);
        drv(NOP, NOP, 1'b0);      chk("rd_idle", NO, 0, 3, 0);

        sdrv(NOP, DIV, 1'b0);     schk("s_div_nostall", NO, 0, 0);
        sdrv(NOP, NOP, 1'b1);
        for (int i = 0; i < 5; i++) begin
            schk("s_br", BR, 0, (i > 3) ? 3 : i);
        end
        sdrv(NOP, NOP, 1'b0);     schk("s_br_sat", NO, 0, 3);
        sdrv(ADD_R3, LD3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            schk("s_lu", LU, i, 3);
        end
        sdrv(NOP, NOP, 1'b0);     schk("s_lu_sat", NO, 3, 3);

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/hazard_interlock_unit.md
Name: hazard_interlock_unit

Overview:
- Stall and flush controller for the 5-stage SimpleRISC pipeline (IF, OF, EX, MA, RW). It complements the src1/src2 forwarding logic.
- It resolves the hazards that forwarding cannot:
  - load-use (ld in EX, consumer in OF): one-cycle bubble.
  - multi-cycle div/mod occupying EX: EX frozen for DIV_LATENCY cycles.
  - taken branch resolved in EX: IF/OF and OF/EX flushed.
- It also keeps saturating stall and flush statistics counters.

Parameters:
- DIV_LATENCY, 4, total cycles a div/mod (opcode 00011/00100) occupies EX. Valid range is 1 or more; 1 means no stall.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- of_ir  in  32  instruction in OF
- ex_ir  in  32  instruction in EX
- branch_taken  in  1  EX branch unit resolved a taken branch/call/ret this cycle
- pc_hold  out  1  PC keeps its value
- if_of_hold  out  1  IF/OF register keeps its value
- if_of_flush  out  1  IF/OF register loads nop (0x68000000)
- of_ex_hold  out  1  OF/EX register keeps its value
- of_ex_bubble  out  1  OF/EX register loads nop
- ex_ma_bubble  out  1  EX/MA register loads nop
- stall_cnt  out  CNT_W  count of cycles with pc_hold=1, saturating
- flush_cnt  out  CNT_W  count of taken-branch flushes, saturating
- state  out  2  FSM state for debug: 0=IDLE, 1=DIV_BUSY

Behaviour:
- Instruction fields: opcode=[31:27], I=[26], rd=[25:22], rs1=[21:18], rs2=[17:14].
- OF reads rs1 unless opcode is one of nop 01101, b 10010, beq 10000, bgt 10001, call 10011, not 01000, mov 01001. For ret (10100) the rs1 value is replaced by ra=15.
- OF reads rs2 when I=0 and opcode is one of ALU 00000..01100 or cmp 00101.
- OF reads rd when opcode is st (01111), as the store data.
- Load-use condition: ex opcode is ld (01110) and an OF read register equals ex rd.
- Div condition: ex opcode is 00011 or 00100.
- Output timing:
  - Outputs are combinational from the current state, of_ir, ex_ir and branch_taken, so they act in the same cycle.
  - State and counters are registered on rising clk.
- Priority: branch_taken > div > load-use.
- Taken branch:
  - Asserts if_of_flush and of_ex_bubble for one cycle.
  - pc_hold=0, so the PC loads the target.
  - flush_cnt increments by 1.
- Load-use:
  - Asserts pc_hold, if_of_hold and of_ex_bubble for exactly one cycle.
  - The next cycle EX holds nop, so the stall does not re-trigger. MA->EX forwarding covers the dependency.
- Div FSM, starting in IDLE with the div condition and DIV_LATENCY≥2:
  - The detection cycle asserts pc_hold, if_of_hold, of_ex_hold and ex_ma_bubble.
  - It loads cnt=DIV_LATENCY-2 and the FSM moves to DIV_BUSY.
- Div FSM, in DIV_BUSY:
  - If cnt≠0: the same four holds are asserted and cnt decrements.
  - If cnt=0: all holds are released and the FSM returns to IDLE. The div moves to MA on this cycle.
  - The div condition is ignored while in DIV_BUSY.
  - Net effect: EX occupancy is DIV_LATENCY cycles, with DIV_LATENCY-1 hold cycles.
- Back-to-back divs: a div arriving in EX right after release re-triggers from IDLE.
- DIV_LATENCY=1: the FSM never leaves IDLE and div raises no holds.
- branch_taken while in DIV_BUSY cannot occur, because EX holds a div. The design still gives it priority: flush outputs are asserted, and the FSM aborts to IDLE with cnt cleared.
- stall_cnt increments by 1 every cycle pc_hold=1. Both counters hold at all-ones.
- Reset (rst_n low, asynchronous, including mid-DIV_BUSY):
  - FSM goes to IDLE; cnt, stall_cnt and flush_cnt go to 0.
  - All control outputs are forced to 0 while rst_n is low.
  - Operation resumes on the first rising clk after rst_n rises.

Test Plan:
- Load-use, rs1: ex_ir=0x74C40004 (ld r3,4[r1]), of_ir=0x010C8000 (add r4,r3,r2) -> pc_hold=if_of_hold=of_ex_bubble=1 for one cycle; next cycle (ex_ir=nop) all 0; stall_cnt=1.
- No hazard and store data: ex_ir=0x74C40004 with of_ir=0x01088000 (add r4,r2,r2) -> no outputs asserted. With of_ir=0x7CD40000 (st r3,0[r5]) -> one-cycle load-use stall.
- Div, DIV_LATENCY=4: ex_ir=0x1959C000 held -> holds and ex_ma_bubble high for 3 cycles, released on the 4th; state 0,1,1,1,0; stall_cnt=3.
- Branch: branch_taken=1 for one cycle -> if_of_flush=of_ex_bubble=1, pc_hold=0, flush_cnt=1. Simultaneous branch_taken with a load-use pattern -> flush only, stall_cnt unchanged.
- Reset mid-div: assert rst_n=0 on the 2nd DIV_BUSY cycle -> outputs immediately 0, state=0, counters=0. After release with ex_ir=div -> a full 3-cycle stall restarts.
- Saturation: CNT_W=2, five branch flushes -> flush_cnt stops at 3.
